// File: rtl/fdct4_row.sv
// fdct4_row: four-point forward integer DCT row stage (HEVC core 64/83/36).
// Collects x0..x3 one sample per handshake into a row register. A full row is
// transformed, rounded with (y+ADD)>>>SHIFT and loaded into an output buffer,
// which then streams y0..y3. Collecting the next row overlaps draining this one.
// Optional feature macro: FDCT_SAT_EN clamps results to the 25-bit signed range.
// When it is undefined, results wrap in two's complement.
module fdct4_row #(
    parameter int DATA_W = 25,
    parameter int SHIFT  = 12,
    parameter int ADD    = 2048
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int ACC_W = 36;
    localparam logic signed [ACC_W-1:0] ADD_A = ACC_W'(ADD);
    localparam logic signed [ACC_W-1:0] C64   = 36'sd64;
    localparam logic signed [ACC_W-1:0] C83   = 36'sd83;
    localparam logic signed [ACC_W-1:0] C36   = 36'sd36;
`ifdef FDCT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 36'sd1;
`endif

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                    state;
    logic [1:0]                in_idx;
    logic [1:0]                out_idx;
    logic                      row_full;
    logic signed [DATA_W-1:0]  x_p0    [4];
    logic signed [DATA_W-1:0]  obuf_p1 [4];
    logic signed [ACC_W-1:0]   y_p0    [4];
    logic                      accept;
    logic                      drain_hs;
    logic                      xfer;

    // Round with offset, floor shift, then narrow to the output width.
    function automatic logic signed [DATA_W-1:0] round_narrow(input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W-1:0] t;
        t = (y + ADD_A) >>> SHIFT;
`ifdef FDCT_SAT_EN
        if (t > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (t < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return t[DATA_W-1:0];
`else
        return t[DATA_W-1:0];
`endif
    endfunction

    // A waiting row moves to the buffer when the buffer is empty or its y3 leaves this edge.
    assign accept    = in_valid && in_ready;
    assign drain_hs  = out_valid && out_ready;
    assign xfer      = row_full && ((state == IDLE) || (drain_hs && (out_idx == 2'd3)));
    assign in_ready  = !row_full || xfer;
    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (out_idx == 2'd3);
    assign out_data  = obuf_p1[out_idx];

    // Stage p0 -> p1: butterfly and coefficient multiply on the collected row.
    always_comb begin
        logic signed [ACC_W-1:0] e0, e1, o0, o1;
        e0 = ACC_W'(x_p0[0]) + ACC_W'(x_p0[3]);
        e1 = ACC_W'(x_p0[1]) + ACC_W'(x_p0[2]);
        o0 = ACC_W'(x_p0[0]) - ACC_W'(x_p0[3]);
        o1 = ACC_W'(x_p0[1]) - ACC_W'(x_p0[2]);
        y_p0[0] = C64 * e0 + C64 * e1;
        y_p0[1] = C83 * o0 + C36 * o1;
        y_p0[2] = C64 * e0 - C64 * e1;
        y_p0[3] = C36 * o0 - C83 * o1;
    end

    // Control: input slot counter, row-full flag and the output drain FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_idx   <= 2'd0;
            row_full <= 1'b0;
            out_idx  <= 2'd0;
            state    <= IDLE;
        end else begin
            if (accept)
                in_idx <= in_idx + 2'd1;
            if (accept && (in_idx == 2'd3))
                row_full <= 1'b1;
            else if (xfer)
                row_full <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state   <= DRAIN;
                        out_idx <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        out_idx <= 2'd0;
                    end else if (drain_hs) begin
                        out_idx <= out_idx + 2'd1;
                        if (out_idx == 2'd3)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row register: each accepted sample lands in its slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                x_p0[i] <= '0;
        end else if (accept) begin
            x_p0[in_idx] <= in_data;
        end
    end

    // Output buffer: rounded coefficients of the waiting row load on transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                obuf_p1[i] <= '0;
        end else if (xfer) begin
            for (int i = 0; i < 4; i++)
                obuf_p1[i] <= round_narrow(y_p0[i]);
        end
    end

endmodule

// File: tb/tb_fdct4_row.sv
// tb_fdct4_row: randomized and directed bench for fdct4_row with a row-level
// arithmetic reference model. A second instance runs with SHIFT=0, ADD=0.
module tb_fdct4_row;

    typedef struct {
        longint d;
        bit     l;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic signed [24:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [24:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    logic signed [24:0] s_in_data;
    logic               s_in_valid;
    logic               s_in_ready;
    logic signed [24:0] s_out_data;
    logic               s_out_valid;
    logic               s_out_ready;
    logic               s_out_last;

    fdct4_row #(.DATA_W(25), .SHIFT(12), .ADD(2048)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    fdct4_row #(.DATA_W(25), .SHIFT(0), .ADD(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_last(s_out_last)
    );

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    ent_t   exp_q[$];
    ent_t   got_q[$];
    ent_t   got2_q[$];
    longint in_q[$];
    int     hs_obs[$];
    int     x3_obs = 0;
    bit     ready_drop = 0;
    bit     hold = 0;
    longint held = 0;
    bit     sender_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Floor division by 2^s, written without shifts.
    function automatic longint fdiv(input longint v, input int s);
        longint p, q;
        p = 1;
        for (int i = 0; i < s; i++) p = p * 2;
        q = v / p;
        if ((v % p) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint narrow(input longint v);
`ifdef FDCT_SAT_EN
        if (v > 16777215) return 16777215;
        if (v < -16777216) return -16777216;
        return v;
`else
        longint m;
        m = v % 33554432;
        if (m < 0) m = m + 33554432;
        if (m > 16777215) m = m - 33554432;
        return m;
`endif
    endfunction

    function automatic void model_row(input longint x0, input longint x1, input longint x2, input longint x3);
        longint y[4];
        ent_t e;
        y[0] = 64 * (x0 + x3) + 64 * (x1 + x2);
        y[1] = 83 * (x0 - x3) + 36 * (x1 - x2);
        y[2] = 64 * (x0 + x3) - 64 * (x1 + x2);
        y[3] = 36 * (x0 - x3) - 83 * (x1 - x2);
        for (int k = 0; k < 4; k++) begin
            e.d = narrow(fdiv(y[k] + 2048, 12));
            e.l = (k == 3);
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic signed [24:0] rnd25();
        int t;
        case ($urandom_range(0, 3))
            0: return {1'b0, {24{1'b1}}};
            1: return {1'b1, 24'd0};
            2: begin
                t = $urandom_range(0, 8191) - 4096;
                return 25'(t);
            end
            default: return 25'($urandom);
        endcase
    endfunction

    // Compare process for the main instance: model, scoreboard and hold checks.
    initial begin
        ent_t e, g;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_q.delete();
                exp_q.delete();
                hold = 0;
            end else begin
                if (in_valid && !in_ready) ready_drop = 1;
                if (hold) begin
                    check("hold_valid", longint'(out_valid), 1);
                    check("hold_data", longint'(out_data), held);
                end
                if (!out_valid) check("last_when_idle", longint'(out_last), 0);
                if (in_valid && in_ready) begin
                    in_q.push_back(longint'(in_data));
                    if (in_q.size() == 4) begin
                        model_row(in_q[0], in_q[1], in_q[2], in_q[3]);
                        in_q.delete();
                        x3_obs = cyc;
                    end
                end
                if (out_valid && out_ready) begin
                    g.d = longint'(out_data);
                    g.l = out_last;
                    got_q.push_back(g);
                    hs_obs.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", g.d, e.d);
                        check("out_last", longint'(g.l), longint'(e.l));
                    end
                end
                hold = out_valid && !out_ready;
                held = longint'(out_data);
            end
        end
    end

    // Capture process for the SHIFT=0 instance.
    initial begin
        ent_t g;
        forever begin
            @(negedge clk);
            if (reset && s_out_valid && s_out_ready) begin
                g.d = longint'(s_out_data);
                g.l = s_out_last;
                got2_q.push_back(g);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Present one sample and hold it until accepted; called just after a rising edge.
    task automatic send(input logic signed [24:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic signed [24:0] a, input logic signed [24:0] b,
                            input logic signed [24:0] c, input logic signed [24:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic wait_got(input int k);
        int n = 0;
        while (got_q.size() < k && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() < k) fail_now("wait_outputs");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    task automatic check_impulse(input string tag);
        longint req[4] = '{64, 83, 64, 36};
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > i) begin
                check({tag, "_data"}, got_q[i].d, req[i]);
                check({tag, "_last"}, longint'(got_q[i].l), (i == 3) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int x3_first;
        int n;
        longint y0_sat;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        s_in_valid = 1'b0;
        s_in_data = '0;
        s_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_last", longint'(out_last), 0);

        // Narrowing of an out-of-range result on the SHIFT=0 instance.
        @(posedge clk); #1;
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = 25'sd16777215;
        repeat (4) @(posedge clk);
        #1 s_in_valid = 1'b0;
        n = 0;
        while (got2_q.size() < 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
`ifdef FDCT_SAT_EN
        y0_sat = 16777215;
`else
        y0_sat = -256;
`endif
        if (got2_q.size() < 4) begin
            fail_now("sat_outputs");
        end else begin
            check("sat_y0", got2_q[0].d, y0_sat);
            check("sat_y1", got2_q[1].d, 0);
            check("sat_y2", got2_q[2].d, 0);
            check("sat_y3", got2_q[3].d, 0);
            check("sat_last", longint'(got2_q[3].l), 1);
        end

        // Impulse row.
        @(posedge clk); #1;
        out_ready = 1'b1;
        got_q.delete();
        send_row(25'sd4096, 25'sd0, 25'sd0, 25'sd0);
        in_valid = 1'b0;
        wait_got(4);
        check_impulse("impulse");

        // Ramp row: negative results must floor.
        @(posedge clk); #1;
        got_q.delete();
        send_row(25'sd100, 25'sd200, 25'sd300, 25'sd400);
        in_valid = 1'b0;
        wait_got(4);
        if (got_q.size() >= 4) begin
            check("ramp_y0", got_q[0].d, 16);
            check("ramp_y1", got_q[1].d, -7);
            check("ramp_y2", got_q[2].d, 0);
            check("ramp_y3", got_q[3].d, -1);
        end

        // Three back-to-back rows with no backpressure.
        @(posedge clk); #1;
        got_q.delete();
        hs_obs.delete();
        ready_drop = 0;
        x3_first = 0;
        for (int i = 0; i < 12; i++) begin
            send(rnd25());
            if (i == 3) x3_first = x3_obs;
        end
        in_valid = 1'b0;
        wait_got(12);
        check("sustain_ready_drop", longint'(ready_drop), 0);
        if (hs_obs.size() >= 12) begin
            check("sustain_first_latency", longint'(hs_obs[0]), longint'(x3_first + 2));
            check("sustain_consecutive", longint'(hs_obs[11]), longint'(hs_obs[0] + 11));
        end

        // Backpressure: sink stalls while rows keep arriving.
        @(posedge clk); #1;
        got_q.delete();
        out_ready = 1'b0;
        sender_done = 0;
        fork
            begin
                send_row(25'sd4096, 25'sd0, 25'sd0, 25'sd0);
                for (int i = 0; i < 8; i++) send(rnd25());
                in_valid = 1'b0;
                sender_done = 1;
            end
        join_none
        wait_valid();
        repeat (10) @(negedge clk);
        check("bp_in_ready_low", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        check("bp_held_y0", longint'(out_data), 64);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (!sender_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sender_done) fail_now("bp_sender");
        wait_got(12);
        check_impulse("bp_row1");
        check("bp_no_leftover", longint'(exp_q.size()), 0);

        // Random valid/ready traffic.
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd25();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rand_drained", longint'(exp_q.size()), 0);

        // Reset during a partial row and a drain at out_idx 2.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        got_q.delete();
        out_ready = 1'b0;
        send_row(rnd25(), rnd25(), rnd25(), rnd25());
        in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        check("pre_reset_drained", longint'(got_q.size()), 2);
        send(rnd25());
        send(rnd25());
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_out_data", longint'(out_data), 0);
        check("mid_rst_out_last", longint'(out_last), 0);
        check("mid_rst_in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        got_q.delete();
        out_ready = 1'b1;
        send_row(25'sd4096, 25'sd0, 25'sd0, 25'sd0);
        in_valid = 1'b0;
        wait_got(4);
        check_impulse("post_reset");
        check("post_reset_count", longint'(got_q.size()), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
